// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave that returns queued words on MISO while capturing MOSI words.
// The SPI pins are oversampled in the clk domain and their edges are detected there.
module spi_slave_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  spi_sck_i,
    input  logic                  spi_csn_i,
    input  logic                  spi_sdi_i,
    output logic                  spi_sdo_o,
    output logic                  tx_underrun_o,
    output logic                  busy_o
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int BIT_W   = $clog2(DATA_WIDTH);
    localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

    localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]   COUNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_STAGES);
    localparam logic [PTR_W-1:0]   PTR_ONE    = PTR_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [BIT_W-1:0]   BIT_ONE    = BIT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [SYNC_STAGES-1:0] sck_sync_reg;
    logic [SYNC_STAGES-1:0] csn_sync_reg;
    logic [SYNC_STAGES-1:0] sdi_sync_reg;
    logic                   sck_d_reg;
    logic                   csn_d_reg;
    logic                   sck_s;
    logic                   csn_s;
    logic                   sdi_s;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   csn_fall;

    logic [FLUSH_W-1:0]     flush_cnt_reg;
    logic                   armed_reg;

    logic [DATA_WIDTH-1:0]  fifo_mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [PTR_W-1:0]       rd_ptr_reg;
    logic [CNT_W-1:0]       count_reg;
    logic [CNT_W-1:0]       count_next;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic                   pop_real;
    logic                   underrun;

    logic [DATA_WIDTH-1:0]  tx_shift_reg;
    logic [DATA_WIDTH-2:0]  rx_shift_reg;
    logic [BIT_W-1:0]       bit_cnt_reg;
    logic [DATA_WIDTH-1:0]  rx_data_reg;
    logic                   rx_valid_reg;
    logic                   underrun_reg;
    logic                   bit_rise;
    logic                   tx_shift_en;
    logic                   word_done;
    logic                   busy;

    // Synchronizer chains; csn idles high so a reset never looks like a select.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_reg <= '0;
            csn_sync_reg <= '1;
            sdi_sync_reg <= '0;
            sck_d_reg    <= 1'b0;
            csn_d_reg    <= 1'b1;
        end else begin
            sck_sync_reg[0] <= spi_sck_i;
            csn_sync_reg[0] <= spi_csn_i;
            sdi_sync_reg[0] <= spi_sdi_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sck_sync_reg[i] <= sck_sync_reg[i-1];
                csn_sync_reg[i] <= csn_sync_reg[i-1];
                sdi_sync_reg[i] <= sdi_sync_reg[i-1];
            end
            sck_d_reg <= sck_s;
            csn_d_reg <= csn_s;
        end
    end

    assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
    assign csn_s    = csn_sync_reg[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync_reg[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d_reg;
    assign sck_fall = ~sck_s & sck_d_reg;
    assign csn_fall = armed_reg & csn_d_reg & ~csn_s;

    // After reset the chain holds forced values; wait until it carries real
    // samples and csn is seen high, so a select held low across reset is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt_reg <= '0;
            armed_reg     <= 1'b0;
        end else if (flush_cnt_reg != FLUSH_DONE) begin
            flush_cnt_reg <= flush_cnt_reg + FLUSH_W'(1);
        end else if (csn_s) begin
            armed_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (csn_s) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (csn_fall) state_next = LOAD;
                LOAD:    state_next = SHIFT;
                SHIFT:   state_next = SHIFT;
                default: state_next = IDLE;
            endcase
        end
    end

    // A deasserted select wins over any edge seen in the same cycle.
    always_comb begin
        busy        = 1'b0;
        pop         = 1'b0;
        bit_rise    = 1'b0;
        tx_shift_en = 1'b0;
        case (state_reg)
            LOAD: begin
                busy = 1'b1;
                pop  = ~csn_s;
            end
            SHIFT: begin
                busy = 1'b1;
                if (!csn_s) begin
                    bit_rise = sck_rise;
                    if (sck_fall) begin
                        if (bit_cnt_reg == '0) begin
                            pop = 1'b1;
                        end else begin
                            tx_shift_en = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign fifo_empty = (count_reg == '0);
    assign push       = tx_valid_i & tx_ready_o;
    assign pop_real   = pop & ~fifo_empty;
    assign underrun   = pop & fifo_empty;
    assign word_done  = bit_rise & (bit_cnt_reg == BIT_LAST);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_reg[wr_ptr_reg] <= tx_data_i;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop_real})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop_real) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || csn_s) begin
            tx_shift_reg <= '0;
        end else if (pop) begin
            tx_shift_reg <= fifo_empty ? '0 : fifo_mem_reg[rd_ptr_reg];
        end else if (tx_shift_en) begin
            tx_shift_reg <= {tx_shift_reg[DATA_WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || csn_s) begin
            bit_cnt_reg  <= '0;
            rx_shift_reg <= '0;
        end else if (bit_rise) begin
            bit_cnt_reg  <= (bit_cnt_reg == BIT_LAST) ? '0 : bit_cnt_reg + BIT_ONE;
            rx_shift_reg <= {rx_shift_reg[DATA_WIDTH-3:0], sdi_s};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            rx_valid_reg <= word_done;
            underrun_reg <= underrun;
            if (word_done) begin
                rx_data_reg <= {rx_shift_reg, sdi_s};
            end
        end
    end

    assign tx_ready_o    = (count_reg < COUNT_FULL);
    assign rx_data_o     = rx_data_reg;
    assign rx_valid_o    = rx_valid_reg;
    assign tx_underrun_o = underrun_reg;
    assign busy_o        = busy;
    assign spi_sdo_o     = (state_reg == SHIFT) & tx_shift_reg[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed and randomized SPI transfers against a queue-based model of the responder.
module tb_spi_slave_responder;

    localparam int DW   = 32;
    localparam int SYNC = 2;
    localparam int HALF = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          spi_sck;
    logic          spi_csn;
    logic          spi_sdi;
    logic          spi_sdo;
    logic          tx_underrun;
    logic          busy;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] rx_q[$];
    int            underrun_cnt = 0;
    logic [DW-1:0] mosi_w[4];
    logic [DW-1:0] miso_w[4];
    logic [DW-1:0] exp_w[4];
    int            exp_under;
    int            und_base;
    logic          ready_at_first;
    logic          busy_after;
    logic          load_push_done;

    spi_slave_responder #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (4),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready),
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .spi_sck_i    (spi_sck),
        .spi_csn_i    (spi_csn),
        .spi_sdi_i    (spi_sdi),
        .spi_sdo_o    (spi_sdo),
        .tx_underrun_o(tx_underrun),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (tx_underrun) underrun_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
        chk({tag, "_rx_data"}, rx_data, 32'd0);
        chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        chk({tag, "_sdo"}, 32'(spi_sdo), 32'd0);
        chk({tag, "_underrun"}, 32'(tx_underrun), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        $display("reset check %s done", tag);
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        model_q.push_back(w);
        $display("push %h (model depth %0d)", w, model_q.size());
    endtask

    // Model: every word slot of a transfer pops the head, or sends zero on underrun.
    task automatic model_pops(input int nwords);
        exp_under = 0;
        for (int w = 0; w < nwords; w++) begin
            if (model_q.size() > 0) begin
                exp_w[w] = model_q.pop_front();
            end else begin
                exp_w[w] = '0;
                exp_under++;
            end
        end
    endtask

    // SPI master, mode 0: MOSI changes with sck low, MISO sampled just before the rise.
    // The final falling sck edge coincides with csn release.
    task automatic do_xfer(input int nbits, input int rst_at, input bit push_on_load,
                           input logic [DW-1:0] pw);
        int pushed;
        pushed = 0;
        rx_q.delete();
        und_base = underrun_cnt;
        for (int w = 0; w < 4; w++) miso_w[w] = '0;
        spi_csn = 1'b0;
        for (int b = 0; b < nbits; b++) begin
            spi_sdi = mosi_w[b/32][31-(b%32)];
            for (int c = 0; c < HALF; c++) begin
                @(negedge clk);
                if (push_on_load) begin
                    if (pushed == 1) begin
                        tx_valid = 1'b0;
                        pushed   = 2;
                    end else if (pushed == 0 && busy) begin
                        tx_data  = pw;
                        tx_valid = 1'b1;
                        pushed   = 1;
                    end
                end
            end
            miso_w[b/32][31-(b%32)] = spi_sdo;
            if (b == 0) ready_at_first = tx_ready;
            spi_sck = 1'b1;
            repeat (HALF) @(negedge clk);
            if (b == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_reset("midrst");
            end
            spi_sck = 1'b0;
            if (b == nbits - 1) spi_csn = 1'b1;
        end
        tx_valid = 1'b0;
        load_push_done = (pushed == 2);
        repeat (SYNC + 2) @(negedge clk);
        busy_after = busy;
        repeat (HALF) @(negedge clk);
        $display("xfer %0d bits: miso0=%h rx_pulses=%0d underruns=%0d",
                 nbits, miso_w[0], rx_q.size(), underrun_cnt - und_base);
    endtask

    task automatic check_words(input string tag, input int nwords, input bit expect_rx);
        for (int w = 0; w < nwords; w++) begin
            chk($sformatf("%s_miso%0d", tag, w), miso_w[w], exp_w[w]);
            if (expect_rx) chk($sformatf("%s_rx%0d", tag, w), rx_q[w], mosi_w[w]);
        end
        chk({tag, "_rx_count"}, 32'(rx_q.size()), expect_rx ? 32'(nwords) : 32'd0);
        chk({tag, "_underruns"}, 32'(underrun_cnt - und_base), 32'(exp_under));
        chk({tag, "_idle_after"}, 32'(busy_after), 32'd0);
    endtask

    initial begin
        int k;
        int n;
        rst      = 1'b1;
        spi_csn  = 1'b1;
        spi_sck  = 1'b0;
        spi_sdi  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Single word, fixed patterns.
        push_word(32'hA5A5_0F0F);
        chk("single_ready", 32'(tx_ready), 32'd1);
        mosi_w[0] = 32'h1C71_C71C;
        model_pops(1);
        do_xfer(32, -1, 1'b0, '0);
        check_words("single", 1, 1'b1);

        // Empty FIFO: zero word, one underrun, rx still captured.
        mosi_w[0] = $urandom;
        model_pops(1);
        do_xfer(32, -1, 1'b0, '0);
        check_words("empty", 1, 1'b1);

        // Full FIFO, four back-to-back words under one select.
        for (int i = 0; i < 4; i++) push_word($urandom);
        chk("full_ready", 32'(tx_ready), 32'd0);
        for (int i = 0; i < 4; i++) mosi_w[i] = $urandom;
        model_pops(4);
        do_xfer(128, -1, 1'b0, '0);
        chk("full_ready_after_pop", 32'(ready_at_first), 32'd1);
        check_words("b2b", 4, 1'b1);

        // Abort after 13 bits drops the word being sent; next transfer gets the next one.
        push_word($urandom);
        push_word($urandom);
        mosi_w[0] = $urandom;
        model_pops(1);
        do_xfer(13, -1, 1'b0, '0);
        chk("abort_rx_count", 32'(rx_q.size()), 32'd0);
        chk("abort_idle", 32'(busy_after), 32'd0);
        mosi_w[0] = $urandom;
        model_pops(1);
        do_xfer(32, -1, 1'b0, '0);
        check_words("after_abort", 1, 1'b1);

        // Push landing in the same cycle as a pop from an empty FIFO.
        mosi_w[0] = $urandom;
        model_pops(1);
        model_q.push_back(32'h0000_0001);
        do_xfer(32, -1, 1'b1, 32'h0000_0001);
        chk("pushpop_seen_load", 32'(load_push_done), 32'd1);
        check_words("pushpop", 1, 1'b1);
        mosi_w[0] = $urandom;
        model_pops(1);
        do_xfer(32, -1, 1'b0, '0);
        check_words("pushpop_next", 1, 1'b1);

        // Randomized fill levels and transfer lengths.
        for (int it = 0; it < 5; it++) begin
            k = $urandom_range(0, 4);
            for (int j = 0; j < k; j++) begin
                if (model_q.size() < 4) push_word($urandom);
            end
            chk($sformatf("rand%0d_ready", it), 32'(tx_ready), 32'(model_q.size() < 4));
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) mosi_w[i] = $urandom;
            model_pops(n);
            do_xfer(n * 32, -1, 1'b0, '0);
            check_words($sformatf("rand%0d", it), n, 1'b1);
        end

        // Reset during a transfer with two words queued.
        push_word($urandom);
        push_word($urandom);
        mosi_w[0] = $urandom;
        do_xfer(32, 19, 1'b0, '0);
        model_q.delete();
        chk("midrst_rx_count", 32'(rx_q.size()), 32'd0);
        chk("midrst_idle", 32'(busy_after), 32'd0);
        mosi_w[0] = $urandom;
        model_pops(1);
        do_xfer(32, -1, 1'b0, '0);
        check_words("post_rst", 1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_responder.md
SPI_SLAVE_RESPONDER -- requirements
Module: spi_slave_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the SPI word length in bits (8..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the TX word FIFO depth (power of 2, >= 2).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, the synchronizer flops on sck/csn/sdi.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port tx_data_i  input  DATA_WIDTH  word to return to the master on MISO.
REQ-007 SHALL have port tx_valid_i  input  1  tx_data_i valid.
REQ-008 SHALL have port tx_ready_o  output  1  FIFO can accept a word (count < FIFO_DEPTH).
REQ-009 SHALL have port rx_data_o  output  DATA_WIDTH  last complete word received on MOSI.
REQ-010 SHALL have port rx_valid_o  output  1  one-cycle pulse, rx_data_o updated.
REQ-011 SHALL have port spi_sck_i  input  1  SPI clock from master (async).
REQ-012 SHALL have port spi_csn_i  input  1  chip select from master, active-low (async).
REQ-013 SHALL have port spi_sdi_i  input  1  MOSI from master's sdo0 (async).
REQ-014 SHALL have port spi_sdo_o  output  1  MISO to master's sdi0.
REQ-015 SHALL have port tx_underrun_o  output  1  one-cycle pulse, word loaded from empty FIFO.
REQ-016 SHALL have port busy_o  output  1  state is not IDLE.

Function
REQ-017 SHALL synchronize spi_sck_i, spi_csn_i, spi_sdi_i through SYNC_STAGES flops; edges are detected by comparing synced value with its one-cycle-delayed copy.
REQ-018 SHALL operate SPI mode 0, MSB first: sample MOSI on sck rise, update MISO on sck fall; clk >= 4x sck frequency.
REQ-019 SHALL implement states IDLE, LOAD, SHIFT.
REQ-020 IDLE -> LOAD on synced csn falling edge; LOAD -> SHIFT after one cycle; SHIFT -> IDLE on synced csn high; any state -> IDLE on synced csn high.
REQ-021 LOAD SHALL pop FIFO head into tx shift register and drive spi_sdo_o = its MSB in the cycle after LOAD; if FIFO empty, load all-zero and pulse tx_underrun_o.
REQ-022 SHIFT, on each detected sck rise: shift synced sdi into rx shift register LSB; increment bit counter (0..DATA_WIDTH-1, wraps to 0).
REQ-023 When counter wraps to 0 on a rise, rx_data_o SHALL take the completed word and rx_valid_o SHALL pulse in the following cycle.
REQ-024 SHIFT, on each detected sck fall: if counter != 0, shift tx register left and present the next bit; if counter == 0 (word boundary), perform a LOAD-equivalent pop (same underrun rule) for back-to-back words without csn toggling.
REQ-025 FIFO push SHALL occur when tx_valid_i && tx_ready_o; tx_ready_o derives from registered count only.
REQ-026 Simultaneous push and pop SHALL both take effect; count unchanged; at empty, pop sees underrun (zero word) and push still lands.
REQ-027 csn deasserted mid-word SHALL discard partial rx bits (no rx_valid_o), reset counter to 0, drop the partially sent tx word; FIFO contents untouched.
REQ-028 spi_sdo_o SHALL be 0 whenever state is IDLE.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.

Reset
REQ-030 On rst high at a clk edge: state IDLE, FIFO empty, count 0, counter 0, shift registers 0, synchronizers to csn=1/sck=0/sdi=0.
REQ-031 Reset outputs: tx_ready_o=1, rx_data_o=0, rx_valid_o=0, spi_sdo_o=0, tx_underrun_o=0, busy_o=0.
REQ-032 rst asserted mid-transfer SHALL abort as REQ-030 irrespective of csn; a new transfer requires a fresh csn falling edge.

Verification
REQ-033 Push 32'hA5A5_0F0F, csn low, 32 sck at clk/16, MOSI 32'h1C71_C71C -> MISO bits 32'hA5A5_0F0F MSB first, one rx_valid_o pulse with rx_data_o=32'h1C71_C71C.
REQ-034 csn low with FIFO empty, 32 sck -> tx_underrun_o single pulse, MISO all 0, rx word still captured.
REQ-035 Push 4 words (FIFO full, tx_ready_o=0), 128 sck under one csn -> four words back-to-back on MISO, four rx_valid_o pulses, tx_ready_o=1 after first pop.
REQ-036 csn high after 13 sck -> no rx_valid_o, busy_o=0 within SYNC_STAGES+2 clk, next transfer sends next FIFO word from bit 31.
REQ-037 Push 32'h0000_0001 on the pop cycle with FIFO empty -> underrun pulse, count=1 after the cycle, word sent in next transfer.
REQ-038 rst pulsed at sck 20 of a transfer with 2 words queued -> all REQ-031 values next cycle, FIFO empty, no rx_valid_o.
